// File: rtl/shift_frame_ctrl.sv
// Serial-to-parallel frame capture: shifts WIDTH qualified bits into a register,
// then offers the word on a valid/ready handshake while dropping bits that arrive meanwhile.
module shift_frame_ctrl #(
  parameter int unsigned WIDTH           = 8,
  parameter bit          FILL_MSB_TO_LSB = 1'b1,
  parameter bit          AUTO_RESTART    = 1'b0,
  localparam int unsigned CNT_W          = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic             i_bit,
  input  logic             i_bit_valid,
  output logic [WIDTH-1:0] o_word,
  output logic             o_word_valid,
  input  logic             i_word_ready,
  output logic             o_busy,
  output logic             o_drop,
  output logic [CNT_W-1:0] o_bit_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [WIDTH-1:0]   word_q, word_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               drop_q, drop_d;
  logic [WIDTH-1:0]   shift_in;

  // Register contents after accepting i_bit in the configured direction
  always_comb begin
    if (FILL_MSB_TO_LSB) begin
      shift_in = {i_bit, shreg_q[WIDTH-1:1]};
    end else begin
      shift_in = {shreg_q[WIDTH-2:0], i_bit};
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    word_d  = word_q;
    count_d = count_q;
    valid_d = valid_q;
    drop_d  = 1'b0;

    if (i_abort) begin
      // Abort beats a same-cycle handshake; the word is treated as consumed.
      state_d = ST_IDLE;
      shreg_d = '0;
      count_d = '0;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (i_bit_valid) drop_d = 1'b1;
          if (i_start) begin
            state_d = ST_SHIFT;
            shreg_d = '0;
            count_d = '0;
          end
        end
        ST_SHIFT: begin
          if (i_bit_valid) begin
            shreg_d = shift_in;
            count_d = count_q + CNT_W'(1);
            if (count_q == CNT_W'(WIDTH - 1)) begin
              state_d = ST_HOLD;
              word_d  = shift_in;
              valid_d = 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (i_bit_valid) drop_d = 1'b1;
          if (i_word_ready) begin
            valid_d = 1'b0;
            count_d = '0;
            shreg_d = '0;
            state_d = AUTO_RESTART ? ST_SHIFT : ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          count_d = '0;
          valid_d = 1'b0;
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      word_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      word_q  <= word_d;
      count_q <= count_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      drop_q  <= drop_d;
    end
  end

  assign o_word       = word_q;
  assign o_word_valid = valid_q;
  assign o_busy       = busy_q;
  assign o_drop       = drop_q;
  assign o_bit_count  = count_q;

endmodule

// File: tb/tb_shift_frame_ctrl.sv
// Directed bench for shift_frame_ctrl: three instances cover FILL=1, FILL=0 and AUTO_RESTART=1.
module tb_shift_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start  [3];
  logic       abrt   [3];
  logic       bitv   [3];
  logic       bitd   [3];
  logic       ready  [3];
  logic [7:0] word   [3];
  logic       wvalid [3];
  logic       busy   [3];
  logic       drop   [3];
  logic [3:0] cnt    [3];

  int vectors;
  int miscompares;

  always #5 clk = ~clk;

  shift_frame_ctrl #(.WIDTH(8), .FILL_MSB_TO_LSB(1'b1), .AUTO_RESTART(1'b0)) u_fill1 (
    .clk(clk), .i_reset(rst), .i_start(start[0]), .i_abort(abrt[0]),
    .i_bit(bitd[0]), .i_bit_valid(bitv[0]), .o_word(word[0]), .o_word_valid(wvalid[0]),
    .i_word_ready(ready[0]), .o_busy(busy[0]), .o_drop(drop[0]), .o_bit_count(cnt[0]));

  shift_frame_ctrl #(.WIDTH(8), .FILL_MSB_TO_LSB(1'b0), .AUTO_RESTART(1'b0)) u_fill0 (
    .clk(clk), .i_reset(rst), .i_start(start[1]), .i_abort(abrt[1]),
    .i_bit(bitd[1]), .i_bit_valid(bitv[1]), .o_word(word[1]), .o_word_valid(wvalid[1]),
    .i_word_ready(ready[1]), .o_busy(busy[1]), .o_drop(drop[1]), .o_bit_count(cnt[1]));

  shift_frame_ctrl #(.WIDTH(8), .FILL_MSB_TO_LSB(1'b1), .AUTO_RESTART(1'b1)) u_auto (
    .clk(clk), .i_reset(rst), .i_start(start[2]), .i_abort(abrt[2]),
    .i_bit(bitd[2]), .i_bit_valid(bitv[2]), .o_word(word[2]), .o_word_valid(wvalid[2]),
    .i_word_ready(ready[2]), .o_busy(busy[2]), .o_drop(drop[2]), .o_bit_count(cnt[2]));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic check_out(input int n, input string tag, input int w, input int v,
                           input int b, input int d, input int c);
    chk($sformatf("%s.u%0d.word", tag, n),  32'(word[n]),   32'(w));
    chk($sformatf("%s.u%0d.valid", tag, n), 32'(wvalid[n]), 32'(v));
    chk($sformatf("%s.u%0d.busy", tag, n),  32'(busy[n]),   32'(b));
    chk($sformatf("%s.u%0d.drop", tag, n),  32'(drop[n]),   32'(d));
    chk($sformatf("%s.u%0d.count", tag, n), 32'(cnt[n]),    32'(c));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input int n, input logic b);
    bitv[n] = 1'b1;
    bitd[n] = b;
    tick();
    bitv[n] = 1'b0;
    bitd[n] = 1'b0;
  endtask

  task automatic do_start(input int n);
    start[n] = 1'b1;
    tick();
    start[n] = 1'b0;
  endtask

  // seq[7] is the first bit on the wire
  task automatic send_frame(input int n, input string tag, input logic [7:0] seq);
    logic [7:0] s;
    s = seq;
    for (int i = 0; i < 8; i++) begin
      send_bit(n, s[7-i]);
      if (i < 7) begin
        chk($sformatf("%s.u%0d.count%0d", tag, n, i), 32'(cnt[n]), 32'(i + 1));
        chk($sformatf("%s.u%0d.novalid%0d", tag, n, i), 32'(wvalid[n]), 32'd0);
      end
    end
  endtask

  initial begin
    int         gaps [8];
    int         ndrop;
    logic [7:0] seq;
    logic       exp_drop;

    vectors     = 0;
    miscompares = 0;
    rst = 1'b1;
    for (int n = 0; n < 3; n++) begin
      start[n] = 1'b0; abrt[n] = 1'b0; bitv[n] = 1'b0; bitd[n] = 1'b0; ready[n] = 1'b0;
    end
    tick();
    tick();
    for (int n = 0; n < 3; n++) check_out(n, "reset", 0, 0, 0, 0, 0);
    rst = 1'b0;

    // Frame 1,0,1,1,0,0,0,1 with ready high, first bit into LSB
    ready[0] = 1'b1;
    do_start(0);
    check_out(0, "t1_start", 0, 0, 1, 0, 0);
    send_frame(0, "t1", 8'hB1);
    check_out(0, "t1_done", 8'h8D, 1, 1, 0, 8);
    tick();
    check_out(0, "t1_hs", 8'h8D, 0, 0, 0, 0);
    tick();
    check_out(0, "t1_idle", 8'h8D, 0, 0, 0, 0);

    // Same frame, first bit into MSB, with gaps between valid bits
    gaps = '{0, 3, 1, 5, 2, 0, 4, 1};
    seq  = 8'hB1;
    ready[1] = 1'b1;
    do_start(1);
    for (int i = 0; i < 8; i++) begin
      for (int g = 0; g < gaps[i]; g++) begin
        tick();
        chk($sformatf("t2.gap_count%0d", i), 32'(cnt[1]), 32'(i));
      end
      send_bit(1, seq[7-i]);
      chk($sformatf("t2.count%0d", i), 32'(cnt[1]), 32'(i + 1));
    end
    check_out(1, "t2_done", 8'hB1, 1, 1, 0, 8);
    tick();
    check_out(1, "t2_hs", 8'hB1, 0, 0, 0, 0);

    // Backpressure: word held for 10 cycles while 3 bits are dropped
    ready[0] = 1'b0;
    do_start(0);
    send_frame(0, "t3", 8'hB1);
    check_out(0, "t3_done", 8'h8D, 1, 1, 0, 8);
    ndrop = 0;
    for (int k = 0; k < 10; k++) begin
      exp_drop = (k == 1) || (k == 4) || (k == 7);
      bitv[0] = exp_drop;
      bitd[0] = 1'b1;
      tick();
      ndrop += int'(drop[0]);
      check_out(0, $sformatf("t3_hold%0d", k), 8'h8D, 1, 1, int'(exp_drop), 8);
    end
    bitv[0] = 1'b0;
    chk("t3.drop_total", 32'(ndrop), 32'd3);
    ready[0] = 1'b1;
    tick();
    check_out(0, "t3_hs", 8'h8D, 0, 0, 0, 0);

    // Abort after 5 bits (bit in abort cycle discarded silently), then a clean 0xFF frame
    do_start(0);
    for (int i = 0; i < 5; i++) begin
      send_bit(0, 1'b1);
      chk($sformatf("t4.count%0d", i), 32'(cnt[0]), 32'(i + 1));
      chk($sformatf("t4.novalid%0d", i), 32'(wvalid[0]), 32'd0);
    end
    abrt[0] = 1'b1; bitv[0] = 1'b1; bitd[0] = 1'b1;
    tick();
    abrt[0] = 1'b0; bitv[0] = 1'b0; bitd[0] = 1'b0;
    check_out(0, "t4_abort", 8'h8D, 0, 0, 0, 0);
    do_start(0);
    send_frame(0, "t4", 8'hFF);
    check_out(0, "t4_done", 8'hFF, 1, 1, 0, 8);
    tick();
    check_out(0, "t4_hs", 8'hFF, 0, 0, 0, 0);

    // Abort coinciding with a handshake
    do_start(0);
    send_frame(0, "t4b", 8'h3C);
    check_out(0, "t4b_done", 8'h3C, 1, 1, 0, 8);
    abrt[0] = 1'b1;
    tick();
    abrt[0] = 1'b0;
    check_out(0, "t4b_abort_hs", 8'h3C, 0, 0, 0, 0);

    // Auto-restart: two frames back to back without a second start
    ready[2] = 1'b1;
    do_start(2);
    send_frame(2, "t5a", 8'hB1);
    check_out(2, "t5a_done", 8'h8D, 1, 1, 0, 8);
    bitv[2] = 1'b1; bitd[2] = 1'b1;
    tick();
    bitv[2] = 1'b0; bitd[2] = 1'b0;
    check_out(2, "t5a_hs", 8'h8D, 0, 1, 1, 0);
    send_frame(2, "t5b", 8'h3C);
    check_out(2, "t5b_done", 8'h3C, 1, 1, 0, 8);
    tick();
    check_out(2, "t5b_hs", 8'h3C, 0, 1, 0, 0);
    abrt[2] = 1'b1;
    tick();
    abrt[2] = 1'b0;
    check_out(2, "t5_abort", 8'h3C, 0, 0, 0, 0);

    // Reset in SHIFT with 4 bits captured
    do_start(0);
    for (int i = 0; i < 4; i++) send_bit(0, 1'b1);
    check_out(0, "t6_shift", 8'h3C, 0, 1, 0, 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_out(0, "t6_rst_shift", 0, 0, 0, 0, 0);

    // Reset in HOLD clears the held word too
    ready[0] = 1'b0;
    do_start(0);
    send_frame(0, "t6", 8'hB1);
    check_out(0, "t6_hold", 8'h8D, 1, 1, 0, 8);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_out(0, "t6_rst_hold", 0, 0, 0, 0, 0);

    // Bits in IDLE: alone, then together with start
    send_bit(0, 1'b1);
    check_out(0, "t6_idle_drop", 0, 0, 0, 1, 0);
    tick();
    check_out(0, "t6_idle_quiet", 0, 0, 0, 0, 0);
    start[0] = 1'b1; bitv[0] = 1'b1; bitd[0] = 1'b1;
    tick();
    start[0] = 1'b0; bitv[0] = 1'b0; bitd[0] = 1'b0;
    check_out(0, "t6_start_drop", 0, 0, 1, 1, 0);
    send_bit(0, 1'b1);
    check_out(0, "t6_first_bit", 0, 0, 1, 0, 1);
    abrt[0] = 1'b1;
    tick();
    abrt[0] = 1'b0;
    check_out(0, "t6_end", 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/shift_frame_ctrl.md
Name: shift_frame_ctrl

Overview:
Sequences capture of one fixed-length serial frame into an internal WIDTH-bit shift register. Counts accepted bits and presents the completed parallel word on a valid/ready handshake. Stalls and flags dropped bits while the downstream consumer back-pressures. Sits between a serial front-end (bit + qualifier) and word-oriented logic.

Parameters:
WIDTH, 8, frame length in bits and o_word width; legal range >= 2.
FILL_MSB_TO_LSB, 1, 1 = bits enter at MSB and shift toward LSB, so the first bit lands in o_word[0]; 0 = bits enter at LSB, so the first bit lands in o_word[WIDTH-1].
AUTO_RESTART, 0, 1 = after a word handshake go straight to SHIFT for the next frame; 0 = return to IDLE.

Ports:
clk  in  1  clock; all logic on posedge.
i_reset  in  1  synchronous, active-high reset.
i_start  in  1  begin a frame; sampled only in IDLE.
i_abort  in  1  cancel the current frame from any state.
i_bit  in  1  serial data bit.
i_bit_valid  in  1  i_bit qualifier; one bit per cycle maximum.
o_word  out  WIDTH  captured frame; stable while o_word_valid=1.
o_word_valid  out  1  completed frame available.
i_word_ready  in  1  consumer accepts o_word.
o_busy  out  1  1 in SHIFT or HOLD.
o_drop  out  1  one-cycle pulse per valid bit discarded in IDLE or HOLD.
o_bit_count  out  clog2(WIDTH+1)  bits accepted in the current frame.

Behaviour:
- Reset (i_reset=1 at posedge): state=IDLE. o_word=0, o_word_valid=0, o_busy=0, o_drop=0, o_bit_count=0. Reset overrides every other input.
- States: IDLE, SHIFT, HOLD. All outputs are registered.
- IDLE:
  - i_start=1: clear the shift register and count, go to SHIFT.
  - i_bit_valid=1 without i_start: bit discarded, o_drop pulses.
  - i_bit_valid together with i_start: that bit is discarded, o_drop pulses; capture begins next cycle.
- SHIFT:
  - On each cycle with i_bit_valid=1: shift i_bit in per FILL_MSB_TO_LSB; count+1.
  - i_bit_valid=0: hold register and count; gaps of any length are allowed.
  - i_start is ignored.
  - When the WIDTH-th bit is accepted, the next cycle has state=HOLD, o_word_valid=1, o_word=full frame, o_bit_count=WIDTH. Latency: o_word_valid rises the cycle after the last bit is sampled.
- HOLD:
  - o_word and o_word_valid are held until i_word_ready=1.
  - Valid bits arriving in HOLD are discarded; o_drop pulses once per bit.
  - Handshake (o_word_valid & i_word_ready): o_word_valid=0 next cycle and count cleared.
  - After handshake with AUTO_RESTART=1: go to SHIFT. A bit valid in the handshake cycle is still dropped; capture starts next cycle.
  - After handshake with AUTO_RESTART=0: go to IDLE.
  - o_word retains its last value after handshake until the next frame completes.
- i_abort (any state, lower priority than reset): next cycle state=IDLE, o_word_valid=0, count=0. The shift register is cleared; o_word is unchanged. A valid bit in the abort cycle is discarded without o_drop.
- i_abort and the handshake in the same cycle: abort wins, but the word counts as consumed.
- o_busy = (state != IDLE). Counter width is clog2(WIDTH+1) and never exceeds WIDTH.

Test Plan:
1. WIDTH=8, FILL=1: i_start, then bits 1,0,1,1,0,0,0,1 (first to last) back-to-back, i_word_ready=1 -> o_word=0x8D, o_word_valid high exactly 1 cycle, starting the cycle after the 8th bit; returns to IDLE.
2. Same bits with FILL=0 and random i_bit_valid gaps of 0-5 cycles -> o_word=0xB1; o_bit_count steps 0..8 only on valid cycles.
3. Backpressure: hold i_word_ready=0 for 10 cycles while driving 3 valid bits -> o_word stays 0x8D, o_drop pulses 3 times; raising ready clears valid the next cycle.
4. Abort after 5 bits, then a new i_start and a full frame 0xFF -> result 0xFF with no residue from the aborted frame; o_word_valid never asserted for the aborted frame.
5. AUTO_RESTART=1: two consecutive frames 0x8D, 0x3C with ready tied high -> two words, no i_start between them, o_busy stays 1.
6. Assert i_reset mid-SHIFT (count=4) and during HOLD -> all outputs 0 the next cycle; a bit in IDLE without start pulses o_drop.
